// File: rtl/alu_if.sv
// alu_if: start/done handshake bundle between the control FSM and the sequential ALU.
interface alu_if #(
    parameter int BITS_DATA   = 32,
    parameter int OPCODE_BITS = 5
);
    logic                   start;
    logic [OPCODE_BITS-1:0] opcode;
    logic [BITS_DATA-1:0]   operando_a;
    logic [BITS_DATA-1:0]   operando_b;
    logic [BITS_DATA-1:0]   resultado;
    logic                   C;
    logic                   S;
    logic                   O;
    logic                   Z;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic                   halted;
    modport master (
        output start, opcode, operando_a, operando_b,
        input  resultado, C, S, O, Z, busy, done, err, halted
    );
    modport slave (
        input  start, opcode, operando_a, operando_b,
        output resultado, C, S, O, Z, busy, done, err, halted
    );
endinterface

// File: rtl/alu_secuencial.sv
// alu_secuencial: registered ALU with single-cycle logic/arith and iterative MUL/DIV/MOD.
// Opcodes: NOP=0 ADD=1 SUB=2 AND=3 OR=4 XOR=5 NOT=6 NEG=7 MUL=8 DIV=9 MOD=10 HLT=31.
module alu_secuencial #(
    parameter int BITS_DATA   = 32,
    parameter int OPCODE_BITS = 5
) (
    input logic  clk,
    input logic  reset,
    alu_if.slave bus
);
    localparam int W  = BITS_DATA;
    localparam int CW = $clog2(BITS_DATA);
    localparam logic [OPCODE_BITS-1:0] OP_NOP = OPCODE_BITS'(0);
    localparam logic [OPCODE_BITS-1:0] OP_ADD = OPCODE_BITS'(1);
    localparam logic [OPCODE_BITS-1:0] OP_SUB = OPCODE_BITS'(2);
    localparam logic [OPCODE_BITS-1:0] OP_AND = OPCODE_BITS'(3);
    localparam logic [OPCODE_BITS-1:0] OP_OR  = OPCODE_BITS'(4);
    localparam logic [OPCODE_BITS-1:0] OP_XOR = OPCODE_BITS'(5);
    localparam logic [OPCODE_BITS-1:0] OP_NOT = OPCODE_BITS'(6);
    localparam logic [OPCODE_BITS-1:0] OP_NEG = OPCODE_BITS'(7);
    localparam logic [OPCODE_BITS-1:0] OP_MUL = OPCODE_BITS'(8);
    localparam logic [OPCODE_BITS-1:0] OP_DIV = OPCODE_BITS'(9);
    localparam logic [OPCODE_BITS-1:0] OP_MOD = OPCODE_BITS'(10);
    localparam logic [OPCODE_BITS-1:0] OP_HLT = OPCODE_BITS'(31);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t                 state_q, state_d;
    logic [OPCODE_BITS-1:0] op_q, op_d;
    logic [W-1:0]           a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   c_q, c_d, s_q, s_d, o_q, o_d, z_q, z_d;
    logic                   done_q, done_d, err_q, err_d, halted_q, halted_d;

    logic         accept, div_in, iter_in;
    logic [W:0]   mul_sum, div_sh, div_diff, add_w, sub_w;
    logic [W-1:0] neg_w, fin_res;
    logic         fin_c, fin_o, fin_err, fin_upd;

    assign accept  = state_q == IDLE && bus.start && !halted_q;
    assign div_in  = bus.opcode == OP_DIV || bus.opcode == OP_MOD;
    assign iter_in = bus.opcode == OP_MUL || (div_in && bus.operando_b != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            c_q      <= 1'b0;
            s_q      <= 1'b0;
            o_q      <= 1'b0;
            z_q      <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            c_q      <= c_d;
            s_q      <= s_d;
            o_q      <= o_d;
            z_q      <= z_d;
            done_q   <= done_d;
            err_q    <= err_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d = state_q == IDLE ? (accept ? (iter_in ? CALC : FIN) : IDLE) :
                  state_q == CALC ? (cnt_q == '0 ? FIN : CALC) : IDLE;
    end

    // Shift-add multiply keeps {hi,lo} as the running product; restoring divide
    // keeps the partial remainder in hi and shifts quotient bits into lo.
    assign mul_sum  = {1'b0, hi_q} + {1'b0, lo_q[0] ? a_q : '0};
    assign div_sh   = {hi_q, lo_q[W-1]};
    assign div_diff = div_sh - {1'b0, b_q};
    assign add_w    = {1'b0, a_q} + {1'b0, b_q};
    assign sub_w    = {1'b0, a_q} - {1'b0, b_q};
    assign neg_w    = '0 - a_q;

    always_comb begin
        fin_res = '0;
        fin_c   = 1'b0;
        fin_o   = 1'b0;
        fin_err = 1'b0;
        fin_upd = 1'b1;
        case (op_q)
            OP_NOP: fin_upd = 1'b0;
            OP_HLT: fin_upd = 1'b0;
            OP_NOT: fin_res = ~a_q;
            OP_AND: fin_res = a_q & b_q;
            OP_OR:  fin_res = a_q | b_q;
            OP_XOR: fin_res = a_q ^ b_q;
            OP_ADD: begin
                fin_res = add_w[W-1:0];
                fin_c   = add_w[W];
                fin_o   = a_q[W-1] == b_q[W-1] && add_w[W-1] != a_q[W-1];
            end
            OP_SUB: begin
                fin_res = sub_w[W-1:0];
                fin_c   = sub_w[W];
                fin_o   = a_q[W-1] != b_q[W-1] && sub_w[W-1] != a_q[W-1];
            end
            OP_NEG: begin
                fin_res = neg_w;
                fin_c   = a_q != '0;
                fin_o   = a_q == {1'b1, {(W-1){1'b0}}};
            end
            OP_MUL: begin
                fin_res = lo_q;
                fin_c   = hi_q != '0;
                fin_o   = hi_q != '0;
            end
            OP_DIV: begin
                fin_res = b_q == '0 ? '1 : lo_q;
                fin_err = b_q == '0;
            end
            OP_MOD: begin
                fin_res = b_q == '0 ? a_q : hi_q;
                fin_err = b_q == '0;
            end
            default: fin_err = 1'b1;
        endcase
    end

    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        c_d      = c_q;
        s_d      = s_q;
        o_d      = o_q;
        z_d      = z_q;
        err_d    = err_q;
        halted_d = halted_q;
        done_d   = state_q == FIN;
        if (accept) begin
            op_d  = bus.opcode;
            a_d   = bus.operando_a;
            b_d   = bus.operando_b;
            hi_d  = '0;
            lo_d  = bus.opcode == OP_MUL ? bus.operando_b : bus.operando_a;
            cnt_d = CW'(W - 1);
        end
        if (state_q == CALC) begin
            cnt_d = cnt_q - 1'b1;
            if (op_q == OP_MUL) begin
                {hi_d, lo_d} = {mul_sum, lo_q[W-1:1]};
            end else begin
                hi_d = div_diff[W] ? div_sh[W-1:0] : div_diff[W-1:0];
                lo_d = {lo_q[W-2:0], ~div_diff[W]};
            end
        end
        if (state_q == FIN) begin
            err_d    = fin_err;
            halted_d = halted_q || op_q == OP_HLT;
            if (fin_upd) begin
                res_d = fin_res;
                c_d   = fin_c;
                o_d   = fin_o;
                s_d   = fin_res[W-1];
                z_d   = fin_res == '0;
            end
        end
    end

    assign bus.resultado = res_q;
    assign bus.C         = c_q;
    assign bus.S         = s_q;
    assign bus.O         = o_q;
    assign bus.Z         = z_q;
    assign bus.busy      = state_q == CALC;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.halted    = halted_q;
endmodule

// File: tb/tb_alu_secuencial.sv
// tb_alu_secuencial: directed vector table plus hand-written multi-cycle sequences.
module tb_alu_secuencial;
    localparam logic [4:0] OP_NOP = 5'd0, OP_ADD = 5'd1, OP_SUB = 5'd2, OP_AND = 5'd3;
    localparam logic [4:0] OP_OR = 5'd4, OP_XOR = 5'd5, OP_NOT = 5'd6, OP_NEG = 5'd7;
    localparam logic [4:0] OP_MUL = 5'd8, OP_DIV = 5'd9, OP_MOD = 5'd10, OP_HLT = 5'd31;
    localparam logic [4:0] OP_ILL = 5'd20;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c;
        logic        s;
        logic        o;
        logic        z;
        logic        err;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t v[24];

    alu_if #(.BITS_DATA(32), .OPCODE_BITS(5)) bus ();
    alu_secuencial #(.BITS_DATA(32), .OPCODE_BITS(5)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        bus.start = 1'b1;
        bus.opcode = op;
        bus.operando_a = a;
        bus.operando_b = b;
        tick();
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, nb, nd;
        v[0]  = '{OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 0, 0, 1, 0, 2};
        v[1]  = '{OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 1, 1, 0, 0, 2};
        v[2]  = '{OP_SUB, 32'h3, 32'h5, 32'hFFFFFFFE, 1, 1, 0, 0, 0, 2};
        v[3]  = '{OP_SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 0, 1, 0, 0, 2};
        v[4]  = '{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 1, 0, 0, 0, 2};
        v[5]  = '{OP_OR, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 0, 0, 0, 0, 0, 2};
        v[6]  = '{OP_XOR, 32'hAAAA5555, 32'hAAAA5555, 32'h0, 0, 0, 0, 1, 0, 2};
        v[7]  = '{OP_NOT, 32'h0, 32'h12345678, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 2};
        v[8]  = '{OP_NEG, 32'h1, 32'h0, 32'hFFFFFFFF, 1, 1, 0, 0, 0, 2};
        v[9]  = '{OP_NEG, 32'h80000000, 32'h0, 32'h80000000, 1, 1, 1, 0, 0, 2};
        v[10] = '{OP_NEG, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 2};
        v[11] = '{OP_MUL, 32'h00010000, 32'h00010000, 32'h0, 1, 0, 1, 1, 0, 34};
        v[12] = '{OP_MUL, 32'h4D2, 32'h162E, 32'h006AE9BC, 0, 0, 0, 0, 0, 34};
        v[13] = '{OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1, 0, 1, 0, 0, 34};
        v[14] = '{OP_DIV, 32'd100, 32'd7, 32'd14, 0, 0, 0, 0, 0, 34};
        v[15] = '{OP_MOD, 32'd100, 32'd7, 32'd2, 0, 0, 0, 0, 0, 34};
        v[16] = '{OP_DIV, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 0, 0, 0, 0, 0, 34};
        v[17] = '{OP_MOD, 32'hFFFFFFFF, 32'd10, 32'd5, 0, 0, 0, 0, 0, 34};
        v[18] = '{OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 0, 1, 0, 0, 1, 2};
        v[19] = '{OP_ADD, 32'd1, 32'd1, 32'd2, 0, 0, 0, 0, 0, 2};
        v[20] = '{OP_MOD, 32'd9, 32'd0, 32'd9, 0, 0, 0, 0, 1, 2};
        v[21] = '{OP_ILL, 32'h1234, 32'h5678, 32'h0, 0, 0, 0, 1, 1, 2};
        v[22] = '{OP_NOP, 32'd5, 32'd5, 32'h0, 0, 0, 0, 1, 0, 2};
        v[23] = '{OP_DIV, 32'd7, 32'd9, 32'h0, 0, 0, 0, 1, 0, 34};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.opcode = '0;
        bus.operando_a = '0;
        bus.operando_b = '0;
        tick();
        tick();
        chk("reset res", bus.resultado, 0);
        chk("reset flags", {bus.C, bus.S, bus.O, bus.Z}, 0);
        chk("reset status", {bus.busy, bus.done, bus.err, bus.halted}, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 24; i++) begin
            run(v[i].op, v[i].a, v[i].b, lat);
            chk($sformatf("v%0d latency", i), lat, v[i].lat);
            chk($sformatf("v%0d res", i), bus.resultado, v[i].res);
            chk($sformatf("v%0d CSOZ", i), {bus.C, bus.S, bus.O, bus.Z}, {v[i].c, v[i].s, v[i].o, v[i].z});
            chk($sformatf("v%0d err", i), bus.err, v[i].err);
            tick();
            chk($sformatf("v%0d done pulse", i), bus.done, 0);
        end

        // MUL with a stray start mid-CALC; busy must stay high for exactly 32 cycles
        bus.start = 1'b1;
        bus.opcode = OP_MUL;
        bus.operando_a = 32'h00010000;
        bus.operando_b = 32'h00010000;
        tick();
        bus.start = 1'b0;
        nb = 0;
        lat = 1;
        while (!bus.done && lat < 60) begin
            if (bus.busy) nb++;
            if (lat == 10) begin
                bus.start = 1'b1;
                bus.opcode = OP_ADD;
                bus.operando_a = 32'd1;
                bus.operando_b = 32'd1;
            end else bus.start = 1'b0;
            tick();
            lat++;
        end
        bus.start = 1'b0;
        chk("mul stray latency", lat, 34);
        chk("mul stray busy cycles", nb, 32);
        chk("mul stray res", bus.resultado, 0);
        chk("mul stray C", bus.C, 1);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done) nd++;
        end
        chk("mul stray extra done", nd, 0);

        // start held into FIN is not a second request
        bus.start = 1'b1;
        bus.opcode = OP_ADD;
        bus.operando_a = 32'd4;
        bus.operando_b = 32'd4;
        tick();
        bus.operando_a = 32'd10;
        bus.operando_b = 32'd10;
        tick();
        bus.start = 1'b0;
        chk("fin start done", bus.done, 1);
        chk("fin start res", bus.resultado, 8);
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done) nd++;
        end
        chk("fin start ignored", nd, 0);

        // reset in the middle of CALC aborts without done
        run(OP_ADD, 32'd2, 32'd3, lat);
        chk("pre-abort res", bus.resultado, 5);
        bus.start = 1'b1;
        bus.opcode = OP_MUL;
        bus.operando_a = 32'd3;
        bus.operando_b = 32'd5;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        chk("abort busy before reset", bus.busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort busy", bus.busy, 0);
        chk("abort res", bus.resultado, 0);
        chk("abort done", bus.done, 0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) nd++;
        end
        chk("abort no done", nd, 0);

        // HLT is sticky until reset and blocks later starts
        run(OP_ADD, 32'd7, 32'd8, lat);
        chk("pre-hlt res", bus.resultado, 15);
        run(OP_HLT, 32'd0, 32'd0, lat);
        chk("hlt latency", lat, 2);
        chk("hlt res kept", bus.resultado, 15);
        chk("hlt halted", bus.halted, 1);
        bus.start = 1'b1;
        bus.opcode = OP_ADD;
        bus.operando_a = 32'd1;
        bus.operando_b = 32'd1;
        tick();
        bus.start = 1'b0;
        nd = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.done) nd++;
        end
        chk("halted add ignored", nd, 0);
        chk("halted res kept", bus.resultado, 15);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("halted cleared", bus.halted, 0);
        chk("post-reset res", bus.resultado, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
